// File: rtl/min2_two_minimum_finder.sv
// ============================================================================
// Module   : min2_two_minimum_finder
// Brief    : Tracks the two smallest (index, value) candidates in a framed
//            stream and publishes them, with a count and boss flag, per frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module min2_two_minimum_finder #(
    parameter int                IDX_W          = 16,
    parameter int                VAL_W          = 14,
    parameter logic [VAL_W-1:0]  BOSS_THRESHOLD = 14'd512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MIN1_Valid,
    input  logic             MIN1_First,
    input  logic             MIN1_Last,
    input  logic [IDX_W-1:0] MIN1_Index,
    input  logic [VAL_W-1:0] MIN1_Value,
    output logic             MIN2_ResultValid,
    output logic             MIN2_TriggerBoss,
    output logic [IDX_W-1:0] MIN2_Minimum1Index,
    output logic [VAL_W-1:0] MIN2_Minimum1Value,
    output logic [IDX_W-1:0] MIN2_Minimum2Index,
    output logic [VAL_W-1:0] MIN2_Minimum2Value,
    output logic [IDX_W-1:0] MIN2_Count,
    output logic             MIN2_Busy
);

    localparam logic [0:0]       c_IDLE    = 1'b0;
    localparam logic [0:0]       c_SCAN    = 1'b1;
    localparam logic [IDX_W-1:0] c_CNT_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic             r_vld1;
    logic [IDX_W-1:0] r_idx1;
    logic [VAL_W-1:0] r_val1;
    logic             r_vld2;
    logic [IDX_W-1:0] r_idx2;
    logic [VAL_W-1:0] r_val2;
    logic [IDX_W-1:0] r_cnt;

    logic             r_res_valid;
    logic             r_boss;
    logic [IDX_W-1:0] r_res_idx1;
    logic [VAL_W-1:0] r_res_val1;
    logic [IDX_W-1:0] r_res_idx2;
    logic [VAL_W-1:0] r_res_val2;
    logic [IDX_W-1:0] r_res_cnt;

    logic             w_accept;
    logic             w_b_vld1;
    logic             w_b_vld2;
    logic             w_n_vld1;
    logic [IDX_W-1:0] w_n_idx1;
    logic [VAL_W-1:0] w_n_val1;
    logic             w_n_vld2;
    logic [IDX_W-1:0] w_n_idx2;
    logic [VAL_W-1:0] w_n_val2;
    logic [IDX_W-1:0] w_n_cnt;

    assign w_accept = MIN1_Valid & (MIN1_First | (r_state == c_SCAN));

    // A First candidate sees empty slots, so a restart discards the partial frame.
    assign w_b_vld1 = r_vld1 & ~MIN1_First;
    assign w_b_vld2 = r_vld2 & ~MIN1_First;

    always_comb begin
        w_n_vld1 = w_b_vld1;
        w_n_idx1 = r_idx1;
        w_n_val1 = r_val1;
        w_n_vld2 = w_b_vld2;
        w_n_idx2 = r_idx2;
        w_n_val2 = r_val2;
        if (!w_b_vld1 || (MIN1_Value < r_val1)) begin
            w_n_vld2 = w_b_vld1;
            w_n_idx2 = r_idx1;
            w_n_val2 = r_val1;
            w_n_vld1 = 1'b1;
            w_n_idx1 = MIN1_Index;
            w_n_val1 = MIN1_Value;
        end else if (!w_b_vld2 || (MIN1_Value < r_val2)) begin
            w_n_vld2 = 1'b1;
            w_n_idx2 = MIN1_Index;
            w_n_val2 = MIN1_Value;
        end
    end

    always_comb begin
        w_n_cnt = r_cnt;
        if (MIN1_First) begin
            w_n_cnt = c_CNT_ONE;
        end else if (!(&r_cnt)) begin
            w_n_cnt = r_cnt + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_vld1      <= 1'b0;
            r_idx1      <= '1;
            r_val1      <= '1;
            r_vld2      <= 1'b0;
            r_idx2      <= '1;
            r_val2      <= '1;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_boss      <= 1'b0;
            r_res_idx1  <= '1;
            r_res_val1  <= '1;
            r_res_idx2  <= '1;
            r_res_val2  <= '1;
            r_res_cnt   <= '0;
        end else begin
            r_res_valid <= 1'b0;
            r_boss      <= 1'b0;
            if (w_accept) begin
                r_vld1 <= w_n_vld1;
                r_idx1 <= w_n_idx1;
                r_val1 <= w_n_val1;
                r_vld2 <= w_n_vld2;
                r_idx2 <= w_n_idx2;
                r_val2 <= w_n_val2;
                r_cnt  <= w_n_cnt;
                if (MIN1_Last) begin
                    r_state     <= c_IDLE;
                    r_res_valid <= 1'b1;
                    r_boss      <= w_n_vld1 & (w_n_val1 < BOSS_THRESHOLD);
                    r_res_idx1  <= w_n_vld1 ? w_n_idx1 : '1;
                    r_res_val1  <= w_n_vld1 ? w_n_val1 : '1;
                    r_res_idx2  <= w_n_vld2 ? w_n_idx2 : '1;
                    r_res_val2  <= w_n_vld2 ? w_n_val2 : '1;
                    r_res_cnt   <= w_n_cnt;
                end else begin
                    r_state <= c_SCAN;
                end
            end
        end
    end

    assign MIN2_ResultValid   = r_res_valid;
    assign MIN2_TriggerBoss   = r_boss;
    assign MIN2_Minimum1Index = r_res_idx1;
    assign MIN2_Minimum1Value = r_res_val1;
    assign MIN2_Minimum2Index = r_res_idx2;
    assign MIN2_Minimum2Value = r_res_val2;
    assign MIN2_Count         = r_res_cnt;
    assign MIN2_Busy          = (r_state == c_SCAN);

endmodule

`default_nettype wire

// File: tb/tb_min2_two_minimum_finder.sv
// ============================================================================
// Module   : tb_min2_two_minimum_finder
// Brief    : Randomized self-checking bench for min2_two_minimum_finder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_min2_two_minimum_finder;

    localparam int IDX_W = 16;
    localparam int VAL_W = 14;
    localparam int BOSS  = 512;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             MIN1_Valid;
    logic             MIN1_First;
    logic             MIN1_Last;
    logic [IDX_W-1:0] MIN1_Index;
    logic [VAL_W-1:0] MIN1_Value;
    logic             MIN2_ResultValid;
    logic             MIN2_TriggerBoss;
    logic [IDX_W-1:0] MIN2_Minimum1Index;
    logic [VAL_W-1:0] MIN2_Minimum1Value;
    logic [IDX_W-1:0] MIN2_Minimum2Index;
    logic [VAL_W-1:0] MIN2_Minimum2Value;
    logic [IDX_W-1:0] MIN2_Count;
    logic             MIN2_Busy;

    min2_two_minimum_finder #(
        .IDX_W          (IDX_W),
        .VAL_W          (VAL_W),
        .BOSS_THRESHOLD (14'd512)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .MIN1_Valid         (MIN1_Valid),
        .MIN1_First         (MIN1_First),
        .MIN1_Last          (MIN1_Last),
        .MIN1_Index         (MIN1_Index),
        .MIN1_Value         (MIN1_Value),
        .MIN2_ResultValid   (MIN2_ResultValid),
        .MIN2_TriggerBoss   (MIN2_TriggerBoss),
        .MIN2_Minimum1Index (MIN2_Minimum1Index),
        .MIN2_Minimum1Value (MIN2_Minimum1Value),
        .MIN2_Minimum2Index (MIN2_Minimum2Index),
        .MIN2_Minimum2Value (MIN2_Minimum2Value),
        .MIN2_Count         (MIN2_Count),
        .MIN2_Busy          (MIN2_Busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the frame is kept as a plain list, minima found by search.
    int q_idx[$];
    int q_val[$];
    bit in_frame;
    bit e_rv, e_boss;
    int e_i1, e_v1, e_i2, e_v2, e_cnt;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_all();
        check_val("result_valid", {31'd0, MIN2_ResultValid}, {31'd0, e_rv});
        check_val("trigger_boss", {31'd0, MIN2_TriggerBoss}, {31'd0, e_boss});
        check_val("busy",         {31'd0, MIN2_Busy},        {31'd0, in_frame});
        check_val("min1_index",   {16'd0, MIN2_Minimum1Index}, e_i1);
        check_val("min1_value",   {18'd0, MIN2_Minimum1Value}, e_v1);
        check_val("min2_index",   {16'd0, MIN2_Minimum2Index}, e_i2);
        check_val("min2_value",   {18'd0, MIN2_Minimum2Value}, e_v2);
        check_val("count",        {16'd0, MIN2_Count},         e_cnt);
    endtask

    task automatic model_reset();
        q_idx.delete();
        q_val.delete();
        in_frame = 0;
        e_rv = 0; e_boss = 0;
        e_i1 = 32'hFFFF; e_v1 = 32'h3FFF;
        e_i2 = 32'hFFFF; e_v2 = 32'h3FFF;
        e_cnt = 0;
    endtask

    // Smallest value wins; among equal values the earliest arrival wins.
    task automatic publish();
        int p1, p2;
        p1 = 0;
        for (int k = 1; k < q_val.size(); k++)
            if (q_val[k] < q_val[p1]) p1 = k;
        p2 = -1;
        for (int k = 0; k < q_val.size(); k++)
            if (k != p1 && (p2 < 0 || q_val[k] < q_val[p2])) p2 = k;
        e_i1 = q_idx[p1];
        e_v1 = q_val[p1];
        if (p2 < 0) begin
            e_i2 = 32'hFFFF; e_v2 = 32'h3FFF;
        end else begin
            e_i2 = q_idx[p2]; e_v2 = q_val[p2];
        end
        e_cnt  = (q_val.size() > 65535) ? 65535 : q_val.size();
        e_boss = (e_v1 < BOSS);
        e_rv   = 1;
    endtask

    task automatic cycle(input bit v, input bit f, input bit l, input int idx, input int val);
        MIN1_Valid = v;
        MIN1_First = f;
        MIN1_Last  = l;
        MIN1_Index = idx[IDX_W-1:0];
        MIN1_Value = val[VAL_W-1:0];
        e_rv = 0;
        e_boss = 0;
        if (v && (f || in_frame)) begin
            if (f) begin
                q_idx.delete();
                q_val.delete();
            end
            q_idx.push_back(idx & 32'hFFFF);
            q_val.push_back(val & 32'h3FFF);
            if (l) begin
                publish();
                in_frame = 0;
                q_idx.delete();
                q_val.delete();
            end else begin
                in_frame = 1;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        model_reset();
        for (int k = 0; k < cycles; k++) begin
            MIN1_Valid = 1'b1;
            MIN1_First = k[0];
            MIN1_Last  = 1'b1;
            MIN1_Index = 16'h0042;
            MIN1_Value = 14'd1;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        MIN1_Valid = 1'b0;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        MIN1_Valid = 0; MIN1_First = 0; MIN1_Last = 0;
        MIN1_Index = '0; MIN1_Value = '0;
        model_reset();
        do_reset(2);

        // Partial frame abandoned by a mid-frame reset, then an orphan Last.
        cycle(1, 1, 0, 0, 3);
        cycle(1, 0, 0, 1, 2);
        do_reset(2);
        check_val("rst_min1_value", {18'd0, MIN2_Minimum1Value}, 32'h3FFF);
        check_val("rst_min1_index", {16'd0, MIN2_Minimum1Index}, 32'hFFFF);
        cycle(1, 0, 1, 2, 1);
        cycle(0, 0, 0, 0, 0);

        cycle(1, 1, 0, 0, 40);
        cycle(1, 0, 0, 1, 10);
        cycle(1, 0, 0, 2, 30);
        cycle(1, 0, 0, 3, 10);
        cycle(1, 0, 1, 4, 5);
        check_val("tp_frame_min1", {MIN2_Minimum1Index, 2'b00, MIN2_Minimum1Value}, {16'd4, 16'd5});
        check_val("tp_frame_min2", {MIN2_Minimum2Index, 2'b00, MIN2_Minimum2Value}, {16'd1, 16'd10});
        check_val("tp_frame_count_boss", {15'd0, MIN2_TriggerBoss, MIN2_Count}, {15'd0, 1'b1, 16'd5});
        cycle(0, 0, 0, 0, 0);

        cycle(1, 1, 0, 10, 7);
        cycle(1, 0, 0, 11, 7);
        cycle(1, 0, 1, 12, 7);
        check_val("tp_tie_min1", {MIN2_Minimum1Index, 2'b00, MIN2_Minimum1Value}, {16'd10, 16'd7});
        check_val("tp_tie_min2", {MIN2_Minimum2Index, 2'b00, MIN2_Minimum2Value}, {16'd11, 16'd7});

        cycle(1, 1, 1, 3, 600);
        check_val("tp_single_min1", {MIN2_Minimum1Index, 2'b00, MIN2_Minimum1Value}, {16'd3, 16'd600});
        check_val("tp_single_min2", {MIN2_Minimum2Index, 2'b00, MIN2_Minimum2Value}, {16'hFFFF, 16'h3FFF});
        check_val("tp_single_count_boss", {15'd0, MIN2_TriggerBoss, MIN2_Count}, {15'd0, 1'b0, 16'd1});

        cycle(1, 1, 0, 0, 1);
        cycle(1, 0, 0, 1, 2);
        cycle(1, 1, 0, 2, 9);
        cycle(1, 0, 1, 3, 8);
        check_val("tp_restart_min1", {MIN2_Minimum1Index, 2'b00, MIN2_Minimum1Value}, {16'd3, 16'd8});
        check_val("tp_restart_min2", {MIN2_Minimum2Index, 2'b00, MIN2_Minimum2Value}, {16'd2, 16'd9});
        check_val("tp_restart_count", {16'd0, MIN2_Count}, 32'd2);

        // Gaps inside a frame, back-to-back First right after Last.
        cycle(1, 1, 0, 20, 100);
        cycle(0, 1, 1, 99, 0);
        cycle(1, 0, 0, 21, 50);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 1, 22, 70);
        cycle(1, 1, 0, 30, 900);
        cycle(1, 0, 1, 31, 800);
        cycle(0, 0, 0, 0, 0);

        for (int n = 0; n < 4000; n++) begin
            int val;
            if ($urandom_range(0, 299) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                case ($urandom_range(0, 2))
                    0: val = $urandom_range(0, 15);
                    1: val = $urandom_range(505, 518);
                    default: val = $urandom_range(0, 16383);
                endcase
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 65535), val);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/min2_two_minimum_finder.md
Name: min2_two_minimum_finder

Overview:
MIN2 stage of the minimum-search pipeline. It consumes a framed stream of (index, value) candidates from MIN1 and tracks the smallest and second-smallest values with their indices. At frame end it publishes both minima plus a boss-trigger flag toward the MIN2/MIN3 pipeline register. Outputs hold between frames.

Parameters:
IDX_W, 16, candidate index width
VAL_W, 14, candidate value width
BOSS_THRESHOLD, 14'd512, MIN2_TriggerBoss fires when final Minimum1Value < this value

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
MIN1_Valid  input  1  candidate present this cycle
MIN1_First  input  1  candidate is first of frame (qualified by MIN1_Valid)
MIN1_Last  input  1  candidate is last of frame (qualified by MIN1_Valid)
MIN1_Index  input  IDX_W  candidate index
MIN1_Value  input  VAL_W  candidate value
MIN2_ResultValid  output  1  one-cycle pulse: result outputs updated
MIN2_TriggerBoss  output  1  one-cycle pulse, coincident with ResultValid, if Minimum1Value < BOSS_THRESHOLD
MIN2_Minimum1Index  output  IDX_W  index of smallest value
MIN2_Minimum1Value  output  VAL_W  smallest value
MIN2_Minimum2Index  output  IDX_W  index of second-smallest value
MIN2_Minimum2Value  output  VAL_W  second-smallest value
MIN2_Count  output  IDX_W  candidates in last completed frame, saturating at all-ones
MIN2_Busy  output  1  high in SCAN state

Behaviour:
- Reset is synchronous, active-low: rst_n sampled low at a rising edge clears the state. All outputs reset to 0, except Minimum1/2 Index = all-ones and Minimum1/2 Value = all-ones (empty sentinel). State goes to IDLE, running slots are emptied, and the running count is set to 0.
- Reset mid-frame abandons the frame. No ResultValid is produced for it.
- State machine, 2 states:
  - IDLE: candidates without First are ignored. Valid&First enters SCAN, or stays in IDLE if Last is also set.
  - SCAN: Valid&Last returns to IDLE.
- Running state: slot1 (vld1, idx1, val1), slot2 (vld2, idx2, val2), 16-bit running count.
- Candidate update, applied at the edge sampling an accepted candidate:
  - If !vld1 or v < val1: slot2 <= slot1, slot1 <= candidate.
  - Else if !vld2 or v < val2: slot2 <= candidate.
  - Else: no change.
- Comparisons are strict unsigned. On ties the earlier candidate keeps the better slot. An equal value can still fill slot2.
- Valid&First (in IDLE or in SCAN) restarts the frame. Slots are treated as empty before this candidate is applied, and count becomes 1. A First arriving mid-SCAN silently discards the partial frame.
- Valid low: no state change, in any state. Gaps inside a frame are allowed.
- Frame completion, on the edge sampling Valid&Last:
  - Result registers load the merged result that includes the last candidate.
  - Empty slots publish sentinel all-ones index/value.
  - MIN2_Count loads the count including the last candidate.
  - ResultValid pulses high for exactly the next cycle, so latency is 1 cycle from the last-candidate edge.
  - TriggerBoss = vld1 & (final val1 < BOSS_THRESHOLD), same cycle as ResultValid. It is never asserted with an empty slot1.
- Valid&First&Last is a one-candidate frame: Minimum1 = candidate, Minimum2 = sentinel, Count = 1, completes in one cycle.
- Back-to-back frames: a First on the cycle right after a Last is accepted. Result outputs hold their values until the next completion.
- Running count saturates at 16'hFFFF and does not wrap.
- Outputs are all registered; there are no combinational input-to-output paths.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles mid-frame, then release -> Minimum values/indices = 0x3FFF/0xFFFF, ResultValid=0, Busy=0; the partial frame produces no result.
- Frame of values 40,10,30,10,5 at indices 0..4 (First@0, Last@4) -> one cycle later ResultValid=1, Min1=(4,5), Min2=(1,10), Count=5, TriggerBoss=1.
- Tie handling: values 7,7,7 at indices 10,11,12 -> Min1=(10,7), Min2=(11,7).
- Single-candidate frame, First&Last with value 600 at index 3 -> Min1=(3,600), Min2=sentinel, Count=1, TriggerBoss=0.
- Restart: First at idx 0 value 1, then idx 1 value 2, then First at idx 2 value 9, then Last at idx 3 value 8 -> Min1=(3,8), Min2=(2,9), Count=2.
- Gaps and back-to-back: Valid low between candidates, plus a new First on the cycle after Last -> both frames produce correct, independent results, each with a single ResultValid pulse.
